// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART that snoops the data-memory store bus.
//   Transmit: the core stores a byte to TXDATA (BASE_ADDR+0) and sets START in
//   CTRL (BASE_ADDR+4); the byte is serialised on tx, LSB first.
//   Receive: each good rx frame becomes a one-cycle bus-master write of the
//   zero-extended byte to RX_ADDR (intr selects the uart side of the memory mux).
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   wen_mem, addr_d_mem, wdata_mem - snooped memory store bus
//   rdata             - memory read data (not used by this block)
//   rx / tx           - serial in / out, both idle high
//   intr, wen_uart, addr_d_uart, wdata_uart - RX bus-master write request
module uart_mmio #(
  parameter int                  WORD_LEN     = 32,
  parameter logic [WORD_LEN-1:0] BASE_ADDR    = 'h1000,
  parameter logic [WORD_LEN-1:0] RX_ADDR      = 'h1010,
  parameter int                  CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen_mem,
  input  logic [WORD_LEN-1:0] addr_d_mem,
  input  logic [WORD_LEN-1:0] wdata_mem,
  input  logic [WORD_LEN-1:0] rdata,
  input  logic                rx,
  output logic                tx,
  output logic                intr,
  output logic                wen_uart,
  output logic [WORD_LEN-1:0] addr_d_uart,
  output logic [WORD_LEN-1:0] wdata_uart
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [WORD_LEN-1:0] uart_regfile [0:7];

  // Register file write decode
  logic wr_hit, wr_txdata, wr_ctrl;
  assign wr_hit    = wen_mem && (addr_d_mem[WORD_LEN-1:3] == BASE_ADDR[WORD_LEN-1:3])
                     && (addr_d_mem[1:0] == 2'b00);
  assign wr_txdata = wr_hit && !addr_d_mem[2];
  assign wr_ctrl   = wr_hit &&  addr_d_mem[2];

  tx_state_t      tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]     tx_bit, tx_bit_n;
  logic [7:0]     tx_sh, tx_sh_n;
  logic           tx_load, tx_done;

  // BUSY is hardware-owned, so a CTRL write carries its next value instead of wdata bit1.
  logic busy_n;
  assign busy_n = tx_load ? 1'b1 : (tx_done ? 1'b0 : uart_regfile[4][1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) uart_regfile[i] <= '0;
    end else begin
      if (tx_load) uart_regfile[4][1] <= 1'b1;
      if (tx_done) uart_regfile[4][1:0] <= 2'b00;
      if (wr_txdata) uart_regfile[0] <= wdata_mem;
      if (wr_ctrl) uart_regfile[4] <= {wdata_mem[WORD_LEN-1:2], busy_n, wdata_mem[0]};
    end
  end

  // TX FSM
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx         = 1'b1;
    tx_load    = 1'b0;
    tx_done    = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (uart_regfile[4][0] && !uart_regfile[4][1]) begin
          tx_load    = 1'b1;
          tx_sh_n    = uart_regfile[0][7:0];
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      TX_DATA: begin
        tx = tx_sh[0];
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
          else tx_bit_n = tx_bit + 1'b1;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_done    = 1'b1;
          tx_state_n = TX_IDLE;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
    end
    tx_sh <= tx_sh_n;
  end

  // RX synchroniser plus one extra flop for falling-edge detection
  logic rx_s1, rx_s2, rx_d;
  rx_state_t      rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]     rx_bit, rx_bit_n;
  logic [7:0]     rx_sh, rx_sh_n;
  logic           rx_ok;

  // RX FSM: the counter phase set at the start-bit midpoint makes every later
  // full-bit wrap land on a bit centre.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_ok      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_s2 && rx_d) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else rx_bit_n = rx_bit + 1'b1;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_STOP: begin
        // A low stop bit discards the byte; the edge detector keeps a
        // still-low line from being taken as a new start bit.
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_ok      = rx_s2;
          rx_state_n = RX_IDLE;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_d        <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      intr        <= 1'b0;
      wen_uart    <= 1'b0;
      addr_d_uart <= '0;
      wdata_uart  <= '0;
    end else begin
      rx_s1       <= rx;
      rx_s2       <= rx_s1;
      rx_d        <= rx_s2;
      rx_state    <= rx_state_n;
      rx_cnt      <= rx_cnt_n;
      rx_bit      <= rx_bit_n;
      intr        <= rx_ok;
      wen_uart    <= rx_ok;
      addr_d_uart <= rx_ok ? RX_ADDR : '0;
      wdata_uart  <= rx_ok ? {{(WORD_LEN-8){1'b0}}, rx_sh_n} : '0;
    end
    rx_sh <= rx_sh_n;
  end

  logic unused;
  assign unused = ^{rdata, uart_regfile[0][WORD_LEN-1:8], uart_regfile[1], uart_regfile[2],
                    uart_regfile[3], uart_regfile[4][WORD_LEN-1:2], uart_regfile[5],
                    uart_regfile[6], uart_regfile[7]};

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: randomized self-checking bench for uart_mmio. A reference model
// tracks the expected register file and RX byte stream; TX frames are compared
// bit-by-bit against a frame built from the byte ({stop, data, start}).
module tb_uart_mmio;
  localparam int          CPB  = 4;
  localparam logic [31:0] BASE = 32'h1000;
  localparam logic [31:0] RXA  = 32'h1010;

  logic        clk = 1'b0;
  logic        rst, wen_mem, rx;
  logic [31:0] addr_d_mem, wdata_mem, rdata;
  logic        tx, intr, wen_uart;
  logic [31:0] addr_d_uart, wdata_uart;

  uart_mmio #(.WORD_LEN(32), .BASE_ADDR(BASE), .RX_ADDR(RXA), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .wen_mem(wen_mem), .addr_d_mem(addr_d_mem),
    .wdata_mem(wdata_mem), .rdata(rdata), .rx(rx), .tx(tx), .intr(intr),
    .wen_uart(wen_uart), .addr_d_uart(addr_d_uart), .wdata_uart(wdata_uart));

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rf [0:7];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          stray = 0;
  bit          mon_en = 0;

  // Record every RX write pulse; any malformed pulse or idle-time noise counts as stray.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (intr === 1'b1) begin
        if (wen_uart !== 1'b1 || addr_d_uart !== RXA) stray++;
        got_q.push_back(wdata_uart);
      end else if (intr !== 1'b0 || wen_uart !== 1'b0 || addr_d_uart !== 32'h0 ||
                   wdata_uart !== 32'h0) stray++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    if (a[31:3] == BASE[31:3] && a[1:0] == 2'b00) begin
      if (a[2]) exp_rf[4] = d & ~32'h2;
      else exp_rf[0] = d;
    end
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr_d_mem = a; wdata_mem = d; wen_mem = 1'b1;
    @(posedge clk); #1;
    wen_mem = 1'b0;
    model_write(a, d);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wen_mem = 1'b0; rx = 1'b1; rdata = 32'h0;
    addr_d_mem = 32'h0; wdata_mem = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_rf[i] = 32'h0;
      checks++;
      if (dut.uart_regfile[i] !== 32'h0) begin
        errors++; $display("FAIL reset_rf[%0d] got=%h exp=0", i, dut.uart_regfile[i]);
      end
    end
    checks++;
    if ({tx, intr, wen_uart} !== 3'b100 || addr_d_uart !== 32'h0 || wdata_uart !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got tx=%b intr=%b wen=%b addr=%h wdata=%h exp 1,0,0,0,0",
               tx, intr, wen_uart, addr_d_uart, wdata_uart);
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic tx_frame(input logic [7:0] b, input logic [31:0] cv, input bit mid);
    logic [9:0] frame;
    bus_write(BASE, {24'h0, b});
    checks++;
    if (dut.uart_regfile[0] !== exp_rf[0]) begin
      errors++; $display("FAIL txdata_wr got=%h exp=%h", dut.uart_regfile[0], exp_rf[0]);
    end
    bus_write(BASE + 32'h4, cv);
    checks++;
    if (dut.uart_regfile[4] !== exp_rf[4]) begin
      errors++; $display("FAIL ctrl_wr got=%h exp=%h", dut.uart_regfile[4], exp_rf[4]);
    end
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== frame[i/CPB]) begin
        errors++; $display("FAIL tx_bit byte=%h cyc=%0d got=%b exp=%b", b, i, tx, frame[i/CPB]);
      end
      if (i == 0) begin
        checks++;
        if (dut.uart_regfile[4] !== (exp_rf[4] | 32'h2)) begin
          errors++;
          $display("FAIL busy_set got=%h exp=%h", dut.uart_regfile[4], exp_rf[4] | 32'h2);
        end
      end
      if (mid) begin
        if (i == 12) begin
          addr_d_mem = BASE; wdata_mem = {24'h0, ~b}; wen_mem = 1'b1;
        end else if (i == 13) begin
          addr_d_mem = BASE + 32'h4; wdata_mem = 32'h1;
        end else if (i == 14) wen_mem = 1'b0;
      end
    end
    if (mid) begin
      exp_rf[0] = {24'h0, ~b};
      exp_rf[4] = 32'h0;
    end else exp_rf[4] = exp_rf[4] & ~32'h3;
    @(posedge clk); #1;
    checks++;
    if (dut.uart_regfile[0] !== exp_rf[0] || dut.uart_regfile[4] !== exp_rf[4]) begin
      errors++;
      $display("FAIL frame_end_rf got=%h/%h exp=%h/%h", dut.uart_regfile[0],
               dut.uart_regfile[4], exp_rf[0], exp_rf[4]);
    end
    for (int i = 0; i < 2 * CPB; i++) begin
      checks++;
      if (tx !== 1'b1) begin
        errors++; $display("FAIL tx_idle_after cyc=%0d got=%b exp=1", i, tx);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_tx();
    tx_frame(8'h55, 32'h1, 0);
    tx_frame(8'h00, 32'h1, 0);
    tx_frame(8'($urandom), 32'hF000_0003, 0);
    tx_frame(8'($urandom), 32'h1, 1);
  endtask

  task automatic compare_rx(input string name);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL %s_data[%0d] got=%h exp=%h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_rx_basic();
    send_rx(8'hA5, 1'b1);
    exp_q.push_back(32'h0000_00A5);
    compare_rx("rx_a5");
  endtask

  task automatic test_rx_framing();
    send_rx(8'h3C, 1'b0);
    compare_rx("rx_framing");
    send_rx(8'h11, 1'b1);
    exp_q.push_back(32'h11);
    compare_rx("rx_after_framing");
  endtask

  task automatic test_rx_random();
    logic [7:0] b;
    logic       s;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_rx(b, s);
      if (s) exp_q.push_back({24'h0, b});
    end
    compare_rx("rx_random");
  endtask

  task automatic test_concurrent();
    logic [7:0] rb;
    rb = 8'($urandom);
    exp_q.push_back({24'h0, rb});
    fork
      tx_frame(8'($urandom), 32'h1, 0);
      begin
        repeat (7) @(posedge clk);
        #1;
        send_rx(rb, 1'b1);
      end
    join
    compare_rx("rx_concurrent");
  endtask

  task automatic test_bad_writes();
    bus_write(32'h1005, 32'hFF);
    bus_write(32'h1008, 32'hFF);
    bus_write(32'h0FFC, 32'hFF);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut.uart_regfile[i] !== exp_rf[i]) begin
        errors++; $display("FAIL bad_write_rf[%0d] got=%h exp=%h", i, dut.uart_regfile[i], exp_rf[i]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL bad_write_tx got=%b exp=1", tx);
    end
  endtask

  task automatic test_reset_mid_tx();
    bus_write(BASE, 32'hAA);
    bus_write(BASE + 32'h4, 32'h1);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) exp_rf[i] = 32'h0;
    checks++;
    if (tx !== 1'b1 || dut.uart_regfile[4] !== 32'h0 || dut.uart_regfile[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_tx got tx=%b ctrl=%h txdata=%h exp 1,0,0", tx,
               dut.uart_regfile[4], dut.uart_regfile[0]);
    end
    checks++;
    if (intr !== 1'b0 || wen_uart !== 1'b0) begin
      errors++; $display("FAIL reset_mid_tx_intr got=%b/%b exp=0/0", intr, wen_uart);
    end
    rst = 1'b0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1) begin
        errors++; $display("FAIL tx_after_reset cyc=%0d got=%b exp=1", i, tx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_basic();
    test_rx_framing();
    test_rx_random();
    test_concurrent();
    test_bad_writes();
    test_reset_mid_tx();
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL rx_bus_pulse_shape got=%0d bad cycles exp=0", stray);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped 8N1 UART that snoops the core's data-memory store bus; it needs no dedicated register-write port.
- Transmit: the core writes a byte and a start bit into a small register file at BASE_ADDR, and the block serialises that byte on tx.
- Receive: each byte arriving on rx is written into main memory by bus-mastering. For one cycle the block asserts intr, which makes the top-level mux give the memory port to wen_uart/addr_d_uart/wdata_uart.

Parameters:
- WORD_LEN, 32, data/address width.
- BASE_ADDR, 32'h1000, base address of the register file. Must be 8-byte aligned.
- RX_ADDR, 32'h1010, memory address receiving each RX byte.
- CLKS_PER_BIT, 4, clock cycles per UART bit. Minimum 2.

Ports:
- clk  in  1  system clock. One clock only; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wen_mem  in  1  memory-bus write enable (muxed core/uart).
- addr_d_mem  in  WORD_LEN  memory-bus byte address.
- wdata_mem  in  WORD_LEN  memory-bus write data.
- rdata  in  WORD_LEN  memory read data. Unused by this block; kept for bus-interface uniformity.
- rx  in  1  serial input, idle high.
- tx  out  1  serial output, idle high.
- intr  out  1  bus-request pulse; selects the uart side of the memory mux.
- wen_uart  out  1  uart memory write enable.
- addr_d_uart  out  WORD_LEN  uart memory write address.
- wdata_uart  out  WORD_LEN  uart memory write data.

Behaviour:
- Register file uart_regfile[0..7], WORD_LEN each, indexed by addr_d_mem[2:0].
  - Only index 0 (TXDATA, bits[7:0] used) and index 4 (CTRL) are writable.
- Write hit condition, all three required:
  - wen_mem=1
  - addr_d_mem[WORD_LEN-1:3]==BASE_ADDR[WORD_LEN-1:3]
  - addr_d_mem[1:0]==0
- On a hit, the entry is updated with wdata_mem at the next rising edge. Misaligned or out-of-range writes are ignored.
- CTRL bit layout:
  - bit0 START: core-written.
  - bit1 BUSY: hardware-owned; core writes to it are ignored.
  - All other bits store as written.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. When START=1 and not busy, load shift register from TXDATA[7:0], set BUSY=1, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then clear START and BUSY together and return to IDLE.
- Writes to TXDATA or CTRL during BUSY update the register but do not restart or alter the frame in flight.
  - If START=1 remains after a frame, it is cleared anyway; the core must rewrite it.
- Latency: the write to CTRL lands at edge N. BUSY reads 1 and tx drops at edge N+1.
- RX path:
  - rx passes through a 2-flop synchroniser.
  - A falling edge while idle starts a frame. The start bit is rechecked at mid-bit (CLKS_PER_BIT/2); if high, it is a glitch and RX returns to idle.
  - 8 data bits are sampled at bit centres, LSB first, then the stop bit.
- Stop bit = 1: for exactly one cycle assert intr=1, wen_uart=1, addr_d_uart=RX_ADDR, wdata_uart={zero-extend, byte}. All return to 0 the next cycle.
- Stop bit = 0 (framing error): byte discarded, no intr. RX returns to idle after the stop-bit period.
- A core write coinciding with intr is lost by the top-level mux; no retry.
  - The block's own RX write is visible on the snooped bus but targets RX_ADDR, outside the register file, so it has no effect.
- TX and RX operate independently and concurrently.
- Reset, at any point mid-frame: all regfile entries 0, FSMs idle, tx=1, intr=0, wen_uart=0, addr_d_uart=0, wdata_uart=0.

Test Plan:
- Reset: rst=1 for 2 cycles -> regfile[0]=regfile[4]=0, tx=1, intr=0, wen_uart=0, addr/wdata_uart=0.
- Write 0x1000 wdata 0x55, then 0x1004 wdata 0x1 -> regfile[0]=0x55; regfile[4]=0x3 one cycle later. tx sequence at 4 clk/bit: 0,1,0,1,0,1,0,1,0,1. After stop bit, regfile[4]=0 and tx=1.
- Write 0x1004 wdata 0x1 with TXDATA=0 -> regfile[4]=0x3 at next edge; frame 0,0×8,1; then regfile[4]=0.
- Drive rx frame for 0xA5 at 4 clk/bit -> exactly one cycle of intr=1, wen_uart=1, addr_d_uart=0x1010, wdata_uart=0x000000A5.
- rx frame 0x3C with stop bit 0 -> intr never asserts; a following valid 0x11 frame yields wdata_uart=0x11.
- Writes to 0x1005, 0x1008, 0x0FFC with wdata 0xFF -> regfile unchanged. Assert rst mid-TX -> tx=1 and BUSY=0 the next cycle.
